pixel_array_readout: RTL and testbench

- Parametrised frame sequencer and readout buffer for the pixel array.
- Drives ERASE, EXPOSE, the analog/digital conversion ramp and the one-hot row READ lines.
- Captures each row of the shared DATA bus and streams rows out over a valid/ready interface.
- Adds what the bare array lacks: programmable exposure, backpressure-safe row buffering, single or continuous frame mode, and a frame counter.

---
 rtl/pixel_array_readout.sv | 166 ++++++++++++++++
 tb/tb_pixel_array_readout.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_array_readout.sv
// Frame sequencer and row readout buffer for the pixel array.
// Runs erase/expose/convert per frame, then streams rows out over valid/ready.
module pixel_array_readout #(
    parameter int HEIGHT       = 2,
    parameter int WIDTH        = 2,
    parameter int PIXEL_BITS   = 8,
    parameter int ERASE_CYCLES = 5,
    parameter int EXP_W        = 8,
    parameter int FRAME_CNT_W  = 8,
    localparam int RW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1,
    localparam int DW = WIDTH * PIXEL_BITS
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic                   START,
    input  logic                   CONTINUOUS,
    input  logic [EXP_W-1:0]       EXPOSE_TIME,
    output logic                   ERASE,
    output logic                   EXPOSE,
    output logic                   ANALOG_RAMP,
    output logic [PIXEL_BITS-1:0]  DIGITAL_RAMP,
    output logic [HEIGHT-1:0]      READ,
    input  logic [DW-1:0]          PIX_DATA,
    output logic                   OUT_VALID,
    input  logic                   OUT_READY,
    output logic [DW-1:0]          OUT_DATA,
    output logic [RW-1:0]          OUT_ROW,
    output logic                   OUT_LAST,
    output logic                   BUSY,
    output logic [FRAME_CNT_W-1:0] FRAME_COUNT
);

    localparam int EW  = $clog2(ERASE_CYCLES + 1);
    localparam int CW0 = (EXP_W > PIXEL_BITS) ? EXP_W : PIXEL_BITS;
    localparam int CW  = (CW0 > EW) ? CW0 : EW;

    localparam logic [CW-1:0] ERASE_LAST = CW'(ERASE_CYCLES - 1);
    localparam logic [CW-1:0] RAMP_LAST  = CW'((1 << PIXEL_BITS) - 1);
    localparam logic [RW-1:0] ROW_LAST   = RW'(HEIGHT - 1);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] ERASE_S  = 3'd1;
    localparam logic [2:0] EXPOSE_S = 3'd2;
    localparam logic [2:0] CONVERT  = 3'd3;
    localparam logic [2:0] READ_S   = 3'd4;
    localparam logic [2:0] HOLD     = 3'd5;

    logic [2:0]       state, state_d;
    logic [CW-1:0]    cnt, cnt_d;
    logic [RW-1:0]    row, row_d;
    logic [EXP_W-1:0] exp_q, exp_d;
    logic [EXP_W-1:0] exp_start;
    logic [CW-1:0]    exp_last;
    logic             frame_done;

    // A zero exposure request still exposes for one cycle.
    assign exp_start = (EXPOSE_TIME == '0) ? EXP_W'(1) : EXPOSE_TIME;
    assign exp_last  = CW'(exp_q) - CW'(1);

    always_comb begin
        state_d    = state;
        cnt_d      = cnt;
        row_d      = row;
        exp_d      = exp_q;
        frame_done = 1'b0;
        case (state)
            IDLE: begin
                if (START) begin
                    state_d = ERASE_S;
                    cnt_d   = '0;
                    exp_d   = exp_start;
                end
            end
            ERASE_S: begin
                if (cnt == ERASE_LAST) begin
                    state_d = EXPOSE_S;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt + CW'(1);
                end
            end
            EXPOSE_S: begin
                if (cnt == exp_last) begin
                    state_d = CONVERT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt + CW'(1);
                end
            end
            CONVERT: begin
                if (cnt == RAMP_LAST) begin
                    state_d = READ_S;
                    cnt_d   = '0;
                    row_d   = '0;
                end else begin
                    cnt_d = cnt + CW'(1);
                end
            end
            READ_S: begin
                state_d = HOLD;
            end
            HOLD: begin
                if (OUT_READY) begin
                    if (row == ROW_LAST) begin
                        frame_done = 1'b1;
                        if (CONTINUOUS) begin
                            state_d = ERASE_S;
                            cnt_d   = '0;
                            exp_d   = exp_start;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        row_d   = row + RW'(1);
                        state_d = READ_S;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs are registered from next-state values so they line up with state.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state        <= IDLE;
            cnt          <= '0;
            row          <= '0;
            exp_q        <= '0;
            ERASE        <= 1'b0;
            EXPOSE       <= 1'b0;
            ANALOG_RAMP  <= 1'b0;
            DIGITAL_RAMP <= '0;
            READ         <= '0;
            OUT_VALID    <= 1'b0;
            OUT_DATA     <= '0;
            OUT_ROW      <= '0;
            OUT_LAST     <= 1'b0;
            BUSY         <= 1'b0;
            FRAME_COUNT  <= '0;
        end else begin
            state        <= state_d;
            cnt          <= cnt_d;
            row          <= row_d;
            exp_q        <= exp_d;
            ERASE        <= (state_d == ERASE_S);
            EXPOSE       <= (state_d == EXPOSE_S);
            ANALOG_RAMP  <= (state_d == CONVERT);
            DIGITAL_RAMP <= (state_d == CONVERT) ? cnt_d[PIXEL_BITS-1:0] : '0;
            READ         <= (state_d == READ_S) ? (HEIGHT'(1) << row_d) : '0;
            OUT_VALID    <= (state_d == HOLD);
            OUT_ROW      <= (state_d == HOLD) ? row_d : '0;
            OUT_LAST     <= (state_d == HOLD) && (row_d == ROW_LAST);
            BUSY         <= (state_d != IDLE);
            if (state == READ_S) begin
                OUT_DATA <= PIX_DATA;
            end
            if (frame_done) begin
                FRAME_COUNT <= FRAME_COUNT + FRAME_CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pixel_array_readout.sv
// Bench for pixel_array_readout: default build plus a 4x3, 4-bit build.
// Rows are checked through scoreboard queues; control timing against a cycle model.
module tb_pixel_array_readout;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic        start0, cont0, ready0;
    logic [7:0]  exp0;
    logic        erase0, expose0, ar0, v0, last0, busy0;
    logic [7:0]  dr0, fc0;
    logic [1:0]  rd0;
    logic [15:0] pix0, od0;
    logic [0:0]  orow0;
    logic [15:0] tab_a, tab_b;

    logic        start1, cont1, ready1;
    logic [7:0]  exp1;
    logic        erase1, expose1, ar1, v1, last1, busy1;
    logic [3:0]  dr1, rd1s;
    logic [11:0] pix1 = '0;
    logic [11:0] od1;
    logic [1:0]  orow1, fc1;

    typedef struct packed {
        logic [15:0] d;
        logic [1:0]  row;
        logic        last;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int n_tests = 0;
    int n_fail  = 0;
    int lasts1  = 0;
    int rdn1    = 0;
    int ramp_i1 = 0;
    int ramp_tot1 = 0;
    int ramp_bad1 = 0;

    pixel_array_readout u0 (
        .CLK(clk), .RESET(rst), .START(start0), .CONTINUOUS(cont0),
        .EXPOSE_TIME(exp0), .ERASE(erase0), .EXPOSE(expose0),
        .ANALOG_RAMP(ar0), .DIGITAL_RAMP(dr0), .READ(rd0),
        .PIX_DATA(pix0), .OUT_VALID(v0), .OUT_READY(ready0),
        .OUT_DATA(od0), .OUT_ROW(orow0), .OUT_LAST(last0),
        .BUSY(busy0), .FRAME_COUNT(fc0)
    );

    pixel_array_readout #(
        .HEIGHT(4), .WIDTH(3), .PIXEL_BITS(4), .ERASE_CYCLES(2),
        .EXP_W(8), .FRAME_CNT_W(2)
    ) u1 (
        .CLK(clk), .RESET(rst), .START(start1), .CONTINUOUS(cont1),
        .EXPOSE_TIME(exp1), .ERASE(erase1), .EXPOSE(expose1),
        .ANALOG_RAMP(ar1), .DIGITAL_RAMP(dr1), .READ(rd1s),
        .PIX_DATA(pix1), .OUT_VALID(v1), .OUT_READY(ready1),
        .OUT_DATA(od1), .OUT_ROW(orow1), .OUT_LAST(last1),
        .BUSY(busy1), .FRAME_COUNT(fc1)
    );

    task automatic check(input string nm, input logic [63:0] act,
                         input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", nm, act, req);
        end
    endtask

    always_comb begin
        pix0 = '0;
        if (rd0[0]) pix0 = tab_a;
        else if (rd0[1]) pix0 = tab_b;
    end

    always @(negedge clk) begin
        exp_t e;
        if (v0 && ready0) begin
            if (q0.size() == 0) begin
                check("sb0_underflow", 1, 0);
            end else begin
                e = q0.pop_front();
                check("u0_row_data", od0, e.d);
                check("u0_row_idx", orow0, e.row);
                check("u0_row_last", last0, e.last);
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (v1 && ready1) begin
            if (q1.size() == 0) begin
                check("sb1_underflow", 1, 0);
            end else begin
                e = q1.pop_front();
                check("u1_row_data", od1, e.d);
                check("u1_row_idx", orow1, e.row);
                check("u1_row_last", last1, e.last);
            end
            if (last1) lasts1++;
        end
    end

    // Drives the u1 column bus and watches its READ walk and ramp.
    always @(negedge clk) begin
        if (rd1s != 0) begin
            check("u1_read_walk", rd1s, 4'b0001 << (rdn1 % 4));
            pix1 = 12'(rdn1 * 37 + 5);
            rdn1++;
        end
        if (ar1) begin
            if (dr1 != 4'(ramp_i1)) ramp_bad1++;
            ramp_i1++;
            ramp_tot1++;
        end else begin
            ramp_i1 = 0;
        end
    end

    task automatic run_frame(input int x, input bit cont, input int next_exp,
                             input logic [15:0] da, input logic [15:0] db,
                             input int restart_k);
        int ce, r, t0, tend, bad, first;
        logic [15:0] got, want, fgot, fwant;
        ce = 5; r = 256; t0 = ce + x + r; tend = t0 + 4;
        bad = 0; first = -1; fgot = '0; fwant = '0;
        tab_a = da; tab_b = db;
        q0.push_back('{d: da, row: 2'd0, last: 1'b0});
        q0.push_back('{d: db, row: 2'd1, last: 1'b1});
        for (int k = 1; k <= tend; k++) begin
            @(negedge clk);
            if (k == 1) begin
                start0 = 1'b0; cont0 = cont; exp0 = 8'(next_exp);
            end
            if (k == restart_k) start0 = 1'b1;
            else if (k == restart_k + 1) start0 = 1'b0;
            want = '0;
            want[15] = (k <= ce);
            want[14] = (k > ce) && (k <= ce + x);
            want[13] = (k > ce + x) && (k <= t0);
            if (want[13]) want[12:5] = 8'(k - ce - x - 1);
            if (k > t0) begin
                if ((k - t0) % 2 == 1) begin
                    want[4:3] = 2'b01 << ((k - t0 - 1) / 2);
                end else begin
                    want[2] = 1'b1;
                    want[1] = ((k - t0 - 2) / 2) == 1;
                end
            end
            want[0] = 1'b1;
            got = {erase0, expose0, ar0, dr0, rd0, v0, last0, busy0};
            if (got !== want) begin
                bad++;
                if (first < 0) begin
                    first = k; fgot = got; fwant = want;
                end
            end
        end
        check($sformatf("frame_ctrl x=%0d cyc=%0d got=%h want=%h",
                        x, first, fgot, fwant), bad, 0);
        if (!cont) begin
            @(negedge clk);
            check("idle_after_frame", busy0, 0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got running required finished");
        $fatal(1, "timeout");
    end

    initial begin
        int w, bad;
        rst = 1'b1;
        start0 = 0; cont0 = 0; ready0 = 1; exp0 = 8'd10;
        start1 = 0; cont1 = 0; ready1 = 1; exp1 = 8'd4;
        tab_a = '0; tab_b = '0;
        repeat (3) @(negedge clk);
        check("reset_u0", {erase0, expose0, ar0, dr0, rd0, v0, od0,
                           orow0, last0, busy0, fc0}, 0);
        check("reset_u1", {erase1, expose1, ar1, dr1, rd1s, v1, od1,
                           orow1, last1, busy1, fc1}, 0);
        rst = 1'b0;

        @(negedge clk); start0 = 1; exp0 = 8'd10;
        run_frame(10, 0, 10, 16'h1234, 16'hBEEF, 0);
        check("fc_after_1", fc0, 1);

        @(posedge clk); #1;
        ready0 = 0; tab_a = 16'hA55A; tab_b = 16'h0FF0;
        q0.push_back('{d: 16'hA55A, row: 2'd0, last: 1'b0});
        q0.push_back('{d: 16'h0FF0, row: 2'd1, last: 1'b1});
        start0 = 1;
        @(posedge clk); #1; start0 = 0;
        w = 0;
        while (!v0 && w < 400) begin @(negedge clk); w++; end
        check("stall_valid_seen", v0, 1);
        bad = 0;
        repeat (20) begin
            if (od0 !== 16'hA55A || rd0 !== 2'b00 || v0 !== 1'b1) bad++;
            @(negedge clk);
        end
        check("stall_hold", bad, 0);
        @(posedge clk); #1; ready0 = 1;
        w = 0;
        while (busy0 && w < 20) begin @(negedge clk); w++; end
        check("stall_idle", busy0, 0);
        check("fc_after_2", fc0, 2);
        check("sb0_drained_stall", q0.size(), 0);

        @(negedge clk); start0 = 1; exp0 = 8'd0;
        run_frame(1, 0, 0, 16'h0001, 16'h8000, 100);
        check("fc_after_3", fc0, 3);

        @(negedge clk); start0 = 1; exp0 = 8'd10;
        run_frame(10, 1, 3, 16'h1111, 16'h2222, 0);
        run_frame(3, 1, 3, 16'h3333, 16'h4444, 0);
        run_frame(3, 0, 3, 16'h5555, 16'h6666, 0);
        check("fc_after_cont", fc0, 6);

        @(negedge clk); start0 = 1; exp0 = 8'd10;
        @(negedge clk); start0 = 0;
        w = 0;
        while (!(ar0 && dr0 == 8'd100) && w < 400) begin
            @(negedge clk); w++;
        end
        check("reached_ramp100", dr0, 100);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_reset_u0", {erase0, expose0, ar0, dr0, rd0, v0, od0,
                               orow0, last0, busy0, fc0}, 0);
        @(negedge clk); start0 = 1;
        run_frame(10, 0, 10, 16'hCAFE, 16'hF00D, 0);
        check("fc_after_reset", fc0, 1);
        check("sb0_drained", q0.size(), 0);

        for (int n = 0; n < 20; n++)
            q1.push_back('{d: 16'(12'(n * 37 + 5)), row: 2'(n % 4),
                           last: (n % 4 == 3)});
        @(negedge clk); start1 = 1; cont1 = 1;
        @(negedge clk); start1 = 0;
        w = 0;
        while (lasts1 < 4 && w < 400) begin @(negedge clk); w++; end
        check("u1_four_frames", lasts1, 4);
        cont1 = 0;
        w = 0;
        while (lasts1 < 5 && w < 400) begin @(negedge clk); w++; end
        check("u1_five_frames", lasts1, 5);
        @(negedge clk);
        check("u1_idle", busy1, 0);
        check("u1_fc_wrap", fc1, 1);
        check("u1_reads", rdn1, 20);
        check("u1_ramp_cycles", ramp_tot1, 80);
        check("u1_ramp_values", ramp_bad1, 0);
        check("sb1_drained", q1.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
